// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: store funct3 encodings,
// store FSM states and the default datapath width.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] FUNCT3_SB = 3'b000;
  localparam logic [2:0] FUNCT3_SH = 3'b001;
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_ACK
  } store_state_t;

endpackage

// File: rtl/store_lane_align.sv
// Byte-lane replication and write strobe for SB/SH/SW.
// STORE_MISALIGN_TRAP_EN enables the misalign flag.
module store_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      ea_lo,
  input  logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic            illegal,
  output logic            misalign
);

  always_comb begin
    wdata    = '0;
    wstrb    = '0;
    illegal  = 1'b0;
    misalign = 1'b0;
    unique case (1'b1)
      (funct3 == FUNCT3_SB): begin
        wdata = {4{rs2_val[7:0]}};
        wstrb = 4'b0001 << ea_lo;
      end
      (funct3 == FUNCT3_SH): begin
        wdata    = {2{rs2_val[15:0]}};
        wstrb    = ea_lo[1] ? 4'b1100 : 4'b0011;
        misalign = ea_lo[0];
      end
      (funct3 == FUNCT3_SW): begin
        wdata    = rs2_val;
        wstrb    = 4'b1111;
        misalign = |ea_lo;
      end
      default: illegal = 1'b1;
    endcase
`ifndef STORE_MISALIGN_TRAP_EN
    misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/store_unit.sv
// S-type store execution with req/gnt/ack memory port.
// STORE_MISALIGN_TRAP_EN traps misaligned SH/SW stores.
module store_unit #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            st_valid,
  output logic            st_ready,
  input  logic [6:0]      imm_s_msb,
  input  logic [4:0]      imm_s_lsb,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_ack,
  output logic            st_done,
  output logic            st_illegal,
  output logic            st_misalign
);

  import riscv_pkg::*;

  store_state_t state, state_nxt;

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] ea;
  logic [XLEN-1:0] al_wdata;
  logic [3:0]      al_wstrb;
  logic            al_illegal;
  logic            al_misalign;
  logic            accept;
  logic            done_nxt;
  logic            ill_nxt;
  logic            mis_nxt;

  assign imm = {{(XLEN-12){imm_s_msb[6]}}, imm_s_msb, imm_s_lsb};
  assign ea  = rs1_val + imm;

  store_lane_align u_align (
    .funct3   (funct3),
    .ea_lo    (ea[1:0]),
    .rs2_val  (rs2_val),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .illegal  (al_illegal),
    .misalign (al_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    st_ready  = 1'b0;
    mem_req   = 1'b0;
    accept    = 1'b0;
    done_nxt  = 1'b0;
    ill_nxt   = 1'b0;
    mis_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        st_ready = 1'b1;
        if (st_valid) begin
          if (al_illegal)       ill_nxt = 1'b1;
          else if (al_misalign) mis_nxt = 1'b1;
          else begin
            accept    = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          if (mem_ack) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        if (mem_ack) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request payload is captured once at accept and held to retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      st_done     <= 1'b0;
      st_illegal  <= 1'b0;
      st_misalign <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr  <= {ea[XLEN-1:2], 2'b00};
        mem_wdata <= al_wdata;
        mem_wstrb <= al_wstrb;
      end
      st_done     <= done_nxt;
      st_illegal  <= ill_nxt;
      st_misalign <= mis_nxt;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit.
// Honors STORE_MISALIGN_TRAP_EN when defined.
module tb_store_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [6:0]  imm_s_msb = '0;
  logic [4:0]  imm_s_lsb = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_ack = 1'b0;
  logic        st_done;
  logic        st_illegal;
  logic        st_misalign;

  int n_tests = 0;
  int n_fail  = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  store_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .imm_s_msb   (imm_s_msb),
    .imm_s_lsb   (imm_s_lsb),
    .funct3      (funct3),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_gnt     (mem_gnt),
    .mem_ack     (mem_ack),
    .st_done     (st_done),
    .st_illegal  (st_illegal),
    .st_misalign (st_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Per-lane reference model of the write the memory should see
  function automatic wr_t model(input logic [2:0] f3,
                                input logic [31:0] rs1,
                                input logic [11:0] imm,
                                input logic [31:0] rs2);
    wr_t w;
    logic [31:0] ea;
    ea = rs1 + {{20{imm[11]}}, imm};
    w.addr = {ea[31:2], 2'b00};
    w.data = '0;
    w.strb = '0;
    for (int b = 0; b < 4; b++) begin
      case (f3)
        3'b000: begin
          w.data[8*b +: 8] = rs2[7:0];
          w.strb[b] = (b == int'(ea[1:0]));
        end
        3'b001: begin
          w.data[8*b +: 8] = rs2[8*(b%2) +: 8];
          w.strb[b] = ((b / 2) == int'(ea[1]));
        end
        default: begin
          w.data[8*b +: 8] = rs2[8*b +: 8];
          w.strb[b] = 1'b1;
        end
      endcase
    end
    return w;
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [11:0] imm, input logic [31:0] rs2);
    st_valid  = 1'b1;
    funct3    = f3;
    imm_s_msb = imm[11:5];
    imm_s_lsb = imm[4:0];
    rs1_val   = rs1;
    rs2_val   = rs2;
    @(negedge clk);
    st_valid  = 1'b0;
  endtask

  task automatic pop_cmp(output wr_t w);
    chk("sb_level", exp_q.size(), 1);
    w = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("addr", mem_addr, w.addr);
    chk("wdata", mem_wdata, w.data);
    chk("wstrb", {28'd0, mem_wstrb}, {28'd0, w.strb});
  endtask

  task automatic run_store(input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [11:0] imm, input logic [31:0] rs2,
                           input wr_t e, input int gd, input int ad);
    wr_t w;
    chk("ready_pre", st_ready, 1);
    exp_q.push_back(e);
    drive(f3, rs1, imm, rs2);
    chk("req_lat", mem_req, 1);
    chk("busy", st_ready, 0);
    pop_cmp(w);
    for (int k = 0; k < gd; k++) begin
      @(negedge clk);
      chk("hold_req", mem_req, 1);
      chk("hold_addr", mem_addr, w.addr);
      chk("hold_data", mem_wdata, w.data);
      chk("early_done", st_done, 0);
    end
    mem_gnt = 1'b1;
    mem_ack = (ad == 0);
    @(negedge clk);
    mem_gnt = 1'b0;
    mem_ack = 1'b0;
    if (ad > 0) begin
      chk("wait_noreq", mem_req, 0);
      for (int k = 1; k < ad; k++) begin
        @(negedge clk);
        chk("wait_noreq", mem_req, 0);
        chk("early_done", st_done, 0);
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    chk("done", st_done, 1);
    chk("ready_post", st_ready, 1);
    @(negedge clk);
    chk("done_pulse", st_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    wr_t w;
    logic [2:0] f3;
    logic [31:0] rs1, rs2;
    logic [11:0] imm;

    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_ready", st_ready, 1);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 0);
    chk("rst_pulses", {29'd0, st_done, st_illegal, st_misalign}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_store(3'b010, 32'h1000, 12'h008, 32'hDEADBEEF,
              '{32'h1008, 32'hDEADBEEF, 4'b1111}, 0, 0);
    run_store(3'b000, 32'h2003, 12'h000, 32'h000000A5,
              '{32'h2000, 32'hA5A5A5A5, 4'b1000}, 0, 0);
    run_store(3'b001, 32'h10, 12'hFFE, 32'h1234,
              '{32'hC, 32'h12341234, 4'b1100}, 3, 2);
    run_store(3'b010, 32'hFFFFFFFC, 12'h008, 32'h55AA00FF,
              '{32'h4, 32'h55AA00FF, 4'b1111}, 1, 1);

`ifdef STORE_MISALIGN_TRAP_EN
    drive(3'b010, 32'h100, 12'h002, 32'hCAFEF00D);
    chk("mis_pulse", st_misalign, 1);
    chk("mis_noreq", mem_req, 0);
    chk("mis_ready", st_ready, 1);
    @(negedge clk);
    chk("mis_once", st_misalign, 0);
    chk("mis_noreq2", mem_req, 0);
`else
    run_store(3'b010, 32'h100, 12'h002, 32'hCAFEF00D,
              '{32'h100, 32'hCAFEF00D, 4'b1111}, 0, 1);
    chk("mis_tied", st_misalign, 0);
`endif

    drive(3'b011, 32'h40, 12'h000, 32'h1);
    chk("ill_pulse", st_illegal, 1);
    chk("ill_noreq", mem_req, 0);
    chk("ill_ready", st_ready, 1);
    @(negedge clk);
    chk("ill_once", st_illegal, 0);
    chk("ill_noreq2", mem_req, 0);

    for (int i = 0; i < 8; i++) begin
      f3  = 3'($urandom_range(0, 2));
      rs1 = $urandom;
      rs2 = $urandom;
      imm = 12'($urandom);
`ifdef STORE_MISALIGN_TRAP_EN
      if (f3 != 3'b000) begin
        rs1[1:0] = 2'b00;
        imm[1:0] = 2'b00;
      end
`endif
      run_store(f3, rs1, imm, rs2, model(f3, rs1, imm, rs2),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    exp_q.push_back(model(3'b010, 32'h300, 12'h000, 32'h77));
    drive(3'b010, 32'h300, 12'h000, 32'h77);
    chk("rq_req", mem_req, 1);
    pop_cmp(w);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rq_wait", mem_req, 0);
    chk("rq_busy", st_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_ready", st_ready, 1);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_done", st_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stale_ack_done", st_done, 0);
    chk("stale_ack_req", mem_req, 0);
    chk("stale_ack_ready", st_ready, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
